// File: rtl/tdm_pkg.sv
// Shared types and helpers for the TDM demultiplexer.
package tdm_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Slot counter width; a single-channel frame still needs a 1-bit counter.
    function automatic int slot_width(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Modulo-N_CH slot counter with clear, load-to-1 and advance controls.
module tdm_slot_counter
    import tdm_pkg::*;
#(
    parameter  int N_CH = 2,
    localparam int SW   = slot_width(N_CH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          advance,
    input  logic          load1,
    input  logic          clear,
    output logic [SW-1:0] slot,
    output logic          last
);

    localparam logic [SW-1:0] LAST_SLOT = SW'(N_CH - 1);
    localparam logic [SW-1:0] ONE_SLOT  = (N_CH > 1) ? SW'(1) : '0;

    assign last = (slot == LAST_SLOT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot <= '0;
        end else if (clear) begin
            slot <= '0;
        end else if (load1) begin
            slot <= ONE_SLOT;
        end else if (advance) begin
            slot <= last ? '0 : slot + SW'(1);
        end
    end

endmodule

// File: rtl/tdm_demux.sv
// TDM demultiplexer: aligns to sync, collects N_CH samples, presents a whole frame.
// Build option: define TDM_DEMUX_STRICT_SYNC_EN to treat a missing slot-0 sync as an error.
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int N_CH = 2,
    parameter int W    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [W-1:0]      din,
    input  logic              din_valid,
    input  logic              sync,
    output logic [N_CH*W-1:0] out,
    output logic              out_valid,
    output logic              err
);

    localparam int SW = slot_width(N_CH);

    state_t              state, state_nx;
    logic [SW-1:0]       slot, wr_slot;
    logic                last;
    logic [N_CH*W-1:0]   shadow, shadow_wr;
    logic                wr_en, wr_zero, complete, err_nx;
    logic                cnt_adv, cnt_load1, cnt_clear;

    tdm_slot_counter #(.N_CH(N_CH)) u_slot_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .advance (cnt_adv),
        .load1   (cnt_load1),
        .clear   (cnt_clear),
        .slot    (slot),
        .last    (last)
    );

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        state_nx  = state;
        wr_en     = 1'b0;
        wr_zero   = 1'b0;
        complete  = 1'b0;
        err_nx    = 1'b0;
        cnt_adv   = 1'b0;
        cnt_load1 = 1'b0;
        cnt_clear = 1'b0;
        if (din_valid) begin
            case (state)
                HUNT: begin
                    if (sync) begin
                        wr_en     = 1'b1;
                        wr_zero   = 1'b1;
                        cnt_load1 = 1'b1;
                        complete  = (N_CH == 1);
                        state_nx  = LOCKED;
                    end
                end
                LOCKED: begin
                    if (sync && slot != '0) begin
                        // Early sync restarts the frame; it never completes one.
                        err_nx    = 1'b1;
                        wr_en     = 1'b1;
                        wr_zero   = 1'b1;
                        cnt_load1 = 1'b1;
                    end else if (!sync && slot == '0) begin
`ifdef TDM_DEMUX_STRICT_SYNC_EN
                        err_nx    = 1'b1;
                        cnt_clear = 1'b1;
                        state_nx  = HUNT;
`else
                        wr_en     = 1'b1;
                        cnt_adv   = 1'b1;
                        complete  = last;
`endif
                    end else begin
                        wr_en    = 1'b1;
                        cnt_adv  = 1'b1;
                        complete = last;
                    end
                end
                default: state_nx = HUNT;
            endcase
        end
    end

    assign wr_slot = wr_zero ? '0 : slot;

    // Shadow with the incoming sample merged in; also the source for a completed frame.
    always_comb begin
        shadow_wr = shadow;
        shadow_wr[wr_slot*W +: W] = din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the shadow is reset as well, so a reset mid-frame leaves no stale samples behind.
            state     <= HUNT;
            shadow    <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state     <= state_nx;
            if (wr_en)    shadow <= shadow_wr;
            if (complete) out    <= shadow_wr;
            out_valid <= complete;
            err       <= err_nx;
        end
    end

endmodule

// File: tb/tb_tdm_demux.sv
// Scoreboard bench for tdm_demux (N_CH=4, W=8): frame-level reference model plus monitor.
`timescale 1ns/1ps
module tb_tdm_demux;

    localparam int N_CH = 4;
    localparam int W    = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [W-1:0]      din = '0;
    logic              din_valid = 1'b0;
    logic              sync = 1'b0;
    logic [N_CH*W-1:0] out;
    logic              out_valid;
    logic              err;

    always #5 clk = ~clk;

    tdm_demux #(.N_CH(N_CH), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .din_valid (din_valid),
        .sync      (sync),
        .out       (out),
        .out_valid (out_valid),
        .err       (err)
    );

    typedef struct {
        int                cyc;
        logic [N_CH*W-1:0] frame;
    } frame_exp_t;

    int                checks = 0;
    int                errors = 0;
    int                cyc = 0;
    frame_exp_t        frame_q[$];
    int                err_q[$];
    logic [W-1:0]      cur[$];
    bit                locked;
    logic [N_CH*W-1:0] last_exp;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        locked = 1'b0;
        cur.delete();
        frame_q.delete();
        err_q.delete();
        last_exp = '0;
    endfunction

    // Reference model: a frame is the list of samples gathered since the last sync.
    function automatic void model_accept(input logic [W-1:0] d, input logic s);
        int                due;
        logic [N_CH*W-1:0] f;
        frame_exp_t        e;
        due = cyc + 1;
        if (!locked) begin
            if (s) begin
                locked = 1'b1;
                cur.delete();
                cur.push_back(d);
            end
        end else if (s && cur.size() != 0) begin
            err_q.push_back(due);
            cur.delete();
            cur.push_back(d);
        end else if (!s && cur.size() == 0) begin
`ifdef TDM_DEMUX_STRICT_SYNC_EN
            err_q.push_back(due);
            locked = 1'b0;
`else
            cur.push_back(d);
`endif
        end else begin
            cur.push_back(d);
        end
        if (cur.size() == N_CH) begin
            f = '0;
            for (int k = 0; k < N_CH; k++) f[k*W +: W] = cur[k];
            e.cyc   = due;
            e.frame = f;
            frame_q.push_back(e);
            cur.delete();
        end
    endfunction

    task automatic send(input logic [W-1:0] d, input logic s);
        @(posedge clk);
        #1;
        din       = d;
        sync      = s;
        din_valid = 1'b1;
        model_accept(d, s);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            din_valid = 1'b0;
            din       = W'($urandom);
            sync      = 1'($urandom);
        end
    endtask

    // Monitor: compares DUT outputs with the scoreboard every cycle, away from the edge.
    initial begin
        bit         ev;
        frame_exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                ev = (frame_q.size() > 0) && (frame_q[0].cyc == cyc);
                check("out_valid", {63'd0, out_valid}, {63'd0, ev});
                if (ev) begin
                    e = frame_q.pop_front();
                    last_exp = e.frame;
                end
                check("out", 64'(out), 64'(last_exp));
                ev = (err_q.size() > 0) && (err_q[0] == cyc);
                check("err", {63'd0, err}, {63'd0, ev});
                if (ev) void'(err_q.pop_front());
            end
        end
    end

    initial begin
        logic s;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_out", 64'(out), 64'd0);
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_err", {63'd0, err}, 64'd0);
        rst_n = 1'b1;
        idle(2);

        // Unsynced samples are ignored while hunting.
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        idle(2);

        // Frame with gaps; sync toggles randomly during gaps and must be ignored.
        send(8'hAA, 1'b1); idle(1);
        send(8'hBB, 1'b0); idle(2);
        send(8'hCC, 1'b0); idle(1);
        send(8'hDD, 1'b0); idle(3);

        // Back-to-back frames at full rate.
        for (int f = 0; f < 3; f++)
            for (int k = 0; k < N_CH; k++) send(W'($urandom), k == 0);

        // Early sync on the 3rd sample; the following samples form the next frame.
        send(8'h01, 1'b1); send(8'h02, 1'b0);
        send(8'h03, 1'b1); send(8'h04, 1'b0); send(8'h05, 1'b0); send(8'h06, 1'b0);

        // Early sync landing on the would-be last slot.
        send(8'h07, 1'b1); send(8'h08, 1'b0); send(8'h09, 1'b0); send(8'h0A, 1'b1);
        send(8'h0B, 1'b0); send(8'h0C, 1'b0); send(8'h0D, 1'b0);

        // Missing sync at slot 0.
        send(8'h0E, 1'b0); send(8'h0F, 1'b0); send(8'h10, 1'b0); send(8'h11, 1'b0);
        send(8'h21, 1'b1); send(8'h22, 1'b0); send(8'h23, 1'b0); send(8'h24, 1'b0);

        // Reset while a frame pulse is showing and a new frame is under way.
        send(8'h31, 1'b1); send(8'h32, 1'b0); send(8'h33, 1'b0); send(8'h34, 1'b0);
        send(8'h41, 1'b1);
        rst_n = 1'b0;
        din_valid = 1'b0;
        model_reset();
        #1;
        check("midrst_out", 64'(out), 64'd0);
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_err", {63'd0, err}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(8'h51, 1'b0); send(8'h52, 1'b0);
        send(8'h61, 1'b1); send(8'h62, 1'b0); send(8'h63, 1'b0); send(8'h64, 1'b0);
        idle(2);

        // Randomized traffic: mostly well-formed frames with occasional framing faults.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(9) < 3) begin
                idle(1);
            end else begin
                if (locked && cur.size() == 0) s = ($urandom_range(7) != 0);
                else                           s = ($urandom_range(11) == 0);
                send(W'($urandom), s);
            end
        end
        idle(4);

        check("frames_drained", 64'(frame_q.size()), 64'd0);
        check("errs_drained", 64'(err_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
